// File: rtl/rr_line_arbiter_if.sv
// rr_line_arbiter_if: bundle of the icache, dcache-side and L2 port signals
// shared by rr_line_arbiter and whatever drives it.
//
// Handshake: a requester raises its read/write request and holds the request,
// address and write data stable until it sees its own resp pulse (resp acts as
// the single-cycle ready/done). It drops the request in the cycle after resp.
// While a request is not yet granted it may change freely; only the value
// present on the grant edge is used. On the L2 side m_read/m_write stay high
// for the whole transfer and m_resp is a one-cycle completion pulse carrying
// m_rdata.
interface rr_line_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // icache side
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    // dcache side (behind the eviction buffer)
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    // L2 port
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_address;
    logic [LINE_W-1:0] m_wdata;
    logic              m_resp;
    logic [LINE_W-1:0] m_rdata;
    // arbiter state, for checkers and debug (0 idle, 1 serving I, 2 serving D)
    logic [1:0]        dbg_state;

    modport slave (
        input  i_read, i_address,
        output i_resp, i_rdata,
        input  d_read, d_write, d_address, d_wdata,
        output d_resp, d_rdata,
        output m_read, m_write, m_address, m_wdata,
        input  m_resp, m_rdata,
        output dbg_state
    );

    modport master (
        output i_read, i_address,
        input  i_resp, i_rdata,
        output d_read, d_write, d_address, d_wdata,
        input  d_resp, d_rdata,
        input  m_read, m_write, m_address, m_wdata,
        output m_resp, m_rdata,
        input  dbg_state
    );
endinterface

// File: rtl/rr_line_arbiter.sv
// rr_line_arbiter: shares one L2 cache-line port between the icache (read
// only) and the dcache side (read/write). One requester is granted at a time;
// its command is latched on the grant edge and driven to L2 until m_resp, and
// the completion is routed back only to the granted side.
//
// Build option: define ARB_DPRIO_EN to make the dcache side win every tie.
// Without it ties alternate (round-robin via last_grant).
module rr_line_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic               clk,
    input  logic               rst,
    rr_line_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;  // 0 = icache, 1 = dcache
    logic                op_write_q, op_write_d;      // latched dcache op
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;

    logic                i_pend;
    logic                d_pend;
    logic                grant_d_side;

    // Decide who would win if the arbiter were idle this cycle.
    always_comb begin
        i_pend = bus.i_read;
        d_pend = bus.d_read | bus.d_write;
`ifdef ARB_DPRIO_EN
        // dcache always wins a tie; last_grant is tracked but not consulted.
        grant_d_side = d_pend;
`else
        // On a tie the side that did not win last time goes next.
        grant_d_side = d_pend & (~i_pend | ~last_grant_q);
`endif
    end

    // Next-state logic: grant in IDLE, return to IDLE on the L2 completion.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_d_side) begin
                    state_d      = ST_SERVE_D;
                    last_grant_d = 1'b1;
                    // A write wins when both d_read and d_write are high.
                    op_write_d   = bus.d_write;
                    addr_d       = bus.d_address;
                    wdata_d      = bus.d_wdata;
                end else if (i_pend) begin
                    state_d      = ST_SERVE_I;
                    last_grant_d = 1'b0;
                    op_write_d   = 1'b0;
                    addr_d       = bus.i_address;
                end
            end
            ST_SERVE_I: begin
                if (bus.m_resp) state_d = ST_IDLE;
            end
            ST_SERVE_D: begin
                if (bus.m_resp) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched command registers; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;  // icache wins the first tie
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Output decode: drive L2 from the latched command, route resp to the owner.
    always_comb begin
        bus.m_read    = 1'b0;
        bus.m_write   = 1'b0;
        bus.m_address = '0;
        bus.m_wdata   = '0;
        bus.i_resp    = 1'b0;
        bus.i_rdata   = '0;
        bus.d_resp    = 1'b0;
        bus.d_rdata   = '0;
        unique case (state_q)
            ST_SERVE_I: begin
                bus.m_read    = 1'b1;
                bus.m_address = addr_q;
                bus.i_resp    = bus.m_resp;
                bus.i_rdata   = bus.m_rdata;
            end
            ST_SERVE_D: begin
                bus.m_read    = ~op_write_q;
                bus.m_write   = op_write_q;
                bus.m_address = addr_q;
                bus.m_wdata   = wdata_q;
                bus.d_resp    = bus.m_resp;
                bus.d_rdata   = bus.m_rdata;
            end
            default: begin
                // IDLE: everything stays at its default of zero; a stray
                // m_resp here goes nowhere.
            end
        endcase
    end

    assign bus.dbg_state = state_q;

    // L2 never sees a read and a write at the same time.
    property p_no_dual_cmd;
        @(posedge clk) disable iff (rst) !(bus.m_read && bus.m_write);
    endproperty
    a_no_dual_cmd: assert property (p_no_dual_cmd);

    // No L2 command and no completion while idle.
    property p_idle_quiet;
        @(posedge clk) disable iff (rst)
            (state_q == ST_IDLE) |-> !(bus.m_read || bus.m_write || bus.i_resp || bus.d_resp);
    endproperty
    a_idle_quiet: assert property (p_idle_quiet);

    // A completion never reaches both sides.
    property p_one_resp;
        @(posedge clk) disable iff (rst) !(bus.i_resp && bus.d_resp);
    endproperty
    a_one_resp: assert property (p_one_resp);

endmodule

// File: tb/tb_rr_line_arbiter.sv
// tb_rr_line_arbiter: directed scenarios followed by a randomized phase with
// two contract-following requesters and a random-latency L2 responder. A
// transaction-level model (who owns the port, which command, what was latched)
// is compared with the DUT on every cycle.
module tb_rr_line_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
`ifdef ARB_DPRIO_EN
    localparam bit DPRIO = 1'b1;
`else
    localparam bit DPRIO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_line_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    rr_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    bit                cur_valid;   // a transfer owns the L2 port
    bit                cur_side;    // 0 = icache, 1 = dcache
    bit                cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [LINE_W-1:0] cur_wdata;
    bit                last_side;
    bit                model_live;
    bit                grant_q[$];

    // ---------------- check helpers ----------------
    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grant history recorded by the model against a hand-written sequence
    // (bit i = side of the i-th grant, 1 = dcache).
    task automatic chk_grants(input string nm, input int n, input logic [7:0] seq);
        chk_v({nm, "_count"}, LINE_W'(grant_q.size()), LINE_W'(n));
        for (int i = 0; i < n && i < grant_q.size(); i++)
            chk1({nm, "_side"}, grant_q[i], seq[i]);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let `lat` cycles pass, pulse m_resp, then drop whichever request was
    // completed (icache may be told to keep its request up).
    task automatic complete(input int lat, input bit keep_i, output bit si, output bit sd);
        repeat (lat) tick();
        bus.m_resp  = 1'b1;
        bus.m_rdata = rand_line();
        #1;
        si = bus.i_resp;
        sd = bus.d_resp;
        tick();
        bus.m_resp = 1'b0;
        if (si && !keep_i) bus.i_read = 1'b0;
        if (sd) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- random-phase agents ----------------
    task automatic i_agent(input int n);
        bit seen;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            seen = bus.i_resp;
            tick();
            if (seen) bus.i_read = 1'b0;
            else if (!bus.i_read && $urandom_range(0, 3) == 0) begin
                bus.i_read    = 1'b1;
                bus.i_address = $urandom;
            end
        end
    endtask

    task automatic d_agent(input int n);
        bit seen;
        int op;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            seen = bus.d_resp;
            tick();
            if (seen) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end else if (!(bus.d_read || bus.d_write) && $urandom_range(0, 2) == 0) begin
                op            = $urandom_range(0, 2);
                bus.d_read    = (op != 1);
                bus.d_write   = (op != 0);
                bus.d_address = $urandom;
                bus.d_wdata   = rand_line();
            end
        end
    endtask

    task automatic l2_agent(input int n);
        int wait_cnt;
        wait_cnt = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (bus.m_resp) bus.m_resp = 1'b0;
            else if (bus.m_read || bus.m_write) begin
                if (wait_cnt == 0) begin
                    bus.m_resp  = 1'b1;
                    bus.m_rdata = rand_line();
                    wait_cnt    = $urandom_range(0, 4);
                end else wait_cnt--;
            end else if ($urandom_range(0, 7) == 0) begin
                // Stray completion while idle must be ignored.
                bus.m_resp  = 1'b1;
                bus.m_rdata = rand_line();
            end
        end
    endtask

    // ---------------- main ----------------
    initial begin
        bit si, sd;
        int d_served;
        logic [LINE_W-1:0] w55;
        logic [LINE_W-1:0] waa;

        checks        = 0;
        failures      = 0;
        model_live    = 1'b0;
        cur_valid     = 1'b0;
        cur_side      = 1'b0;
        cur_write     = 1'b0;
        cur_addr      = '0;
        cur_wdata     = '0;
        last_side     = 1'b1;
        rst           = 1'b1;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.m_resp    = 1'b1;
        bus.m_rdata   = {8{32'hDEADBEEF}};
        w55           = {8{32'h55555555}};
        waa           = {8{32'hAAAAAAAA}};

        // Model: transaction-level view updated on every rising edge.
        fork
            forever begin
                @(posedge clk);
                if (rst) begin
                    cur_valid = 1'b0;
                    last_side = 1'b1;
                end else if (cur_valid) begin
                    if (bus.m_resp) cur_valid = 1'b0;
                end else if (bus.i_read || bus.d_read || bus.d_write) begin
                    if (bus.i_read && (bus.d_read || bus.d_write))
                        cur_side = DPRIO ? 1'b1 : !last_side;
                    else
                        cur_side = !bus.i_read;
                    cur_valid = 1'b1;
                    cur_write = cur_side && bus.d_write;
                    cur_addr  = cur_side ? bus.d_address : bus.i_address;
                    cur_wdata = bus.d_wdata;
                    last_side = cur_side;
                    grant_q.push_back(cur_side);
                end
                model_live = 1'b1;
            end
            // Compare: every falling edge once the model has seen an edge.
            forever begin
                @(negedge clk);
                if (model_live) begin
                    chk1("m_read", bus.m_read, cur_valid && !cur_write);
                    chk1("m_write", bus.m_write, cur_valid && cur_write);
                    chk1("i_resp", bus.i_resp, cur_valid && !cur_side && bus.m_resp);
                    chk1("d_resp", bus.d_resp, cur_valid && cur_side && bus.m_resp);
                    if (cur_valid) chk_v("m_address", LINE_W'(bus.m_address), LINE_W'(cur_addr));
                    if (cur_valid && cur_write) chk_v("m_wdata", bus.m_wdata, cur_wdata);
                    if (bus.i_resp) chk_v("i_rdata", bus.i_rdata, bus.m_rdata);
                    if (bus.d_resp) chk_v("d_rdata", bus.d_rdata, bus.m_rdata);
                end
            end
        join_none

        // Reset: every output zero even with m_resp/m_rdata active.
        repeat (2) tick();
        chk1("rst_m_read", bus.m_read, 1'b0);
        chk1("rst_m_write", bus.m_write, 1'b0);
        chk1("rst_i_resp", bus.i_resp, 1'b0);
        chk1("rst_d_resp", bus.d_resp, 1'b0);
        chk_v("rst_m_address", LINE_W'(bus.m_address), '0);
        chk_v("rst_m_wdata", bus.m_wdata, '0);
        chk_v("rst_i_rdata", bus.i_rdata, '0);
        chk_v("rst_d_rdata", bus.d_rdata, '0);
        rst        = 1'b0;
        bus.m_resp = 1'b0;

        // icache read only: command next cycle, response after 5 cycles.
        bus.i_read    = 1'b1;
        bus.i_address = 32'h60;
        tick();
        chk1("t1_m_read", bus.m_read, 1'b1);
        chk1("t1_m_write", bus.m_write, 1'b0);
        chk_v("t1_m_address", LINE_W'(bus.m_address), LINE_W'(32'h60));
        repeat (4) tick();
        bus.m_resp  = 1'b1;
        bus.m_rdata = waa;
        #1;
        chk1("t1_i_resp", bus.i_resp, 1'b1);
        chk_v("t1_i_rdata", bus.i_rdata, waa);
        chk1("t1_d_resp", bus.d_resp, 1'b0);
        tick();
        bus.m_resp = 1'b0;
        bus.i_read = 1'b0;
        chk1("t1_idle", bus.m_read, 1'b0);

        // dcache write: latched wdata survives a mid-transfer change.
        bus.d_write   = 1'b1;
        bus.d_address = 32'h1000;
        bus.d_wdata   = w55;
        tick();
        chk1("t2_m_write", bus.m_write, 1'b1);
        chk1("t2_m_read", bus.m_read, 1'b0);
        chk_v("t2_m_wdata", bus.m_wdata, w55);
        chk_v("t2_m_address", LINE_W'(bus.m_address), LINE_W'(32'h1000));
        bus.d_wdata = {8{32'h33333333}};
        tick();
        chk_v("t2_m_wdata_held", bus.m_wdata, w55);
        complete(0, 1'b0, si, sd);
        chk1("t2_d_done", sd, 1'b1);
        chk1("t2_i_quiet", si, 1'b0);

        // Ties after reset: I then D then I (D, I, D with dcache priority).
        do_reset();
        grant_q.delete();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h100;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h200;
        tick();
        chk_v("t3_first_addr", LINE_W'(bus.m_address), DPRIO ? LINE_W'(32'h200) : LINE_W'(32'h100));
        complete(1, 1'b0, si, sd);
        complete(1, 1'b0, si, sd);
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        tick();
        complete(0, 1'b0, si, sd);
        chk_grants("t3_grants", 3, DPRIO ? 8'b101 : 8'b010);

        // Back-to-back: icache holds its request, dcache issues 3 reads.
        do_reset();
        grant_q.delete();
        d_served   = 0;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk1("t4_cmd", bus.m_read || bus.m_write, 1'b1);
            if (!bus.d_read && d_served < 3) bus.d_read = 1'b1;
            complete(0, 1'b1, si, sd);
            if (sd) d_served++;
            chk1("t4_gap", bus.m_read || bus.m_write, 1'b0);
        end
        bus.i_read = 1'b0;
        tick();
        chk1("t4_end_idle", bus.m_read, 1'b0);
        chk_grants("t4_grants", 6, DPRIO ? 8'b010101 : 8'b101010);

        // Reset mid-SERVE_D, then a late m_resp is ignored.
        bus.d_read    = 1'b1;
        bus.d_address = 32'h2000;
        tick();
        tick();
        do_reset();
        bus.d_read = 1'b0;
        bus.m_resp = 1'b1;
        #1;
        chk1("t5_d_resp", bus.d_resp, 1'b0);
        chk1("t5_i_resp", bus.i_resp, 1'b0);
        chk1("t5_m_read", bus.m_read, 1'b0);
        chk1("t5_m_write", bus.m_write, 1'b0);
        tick();
        bus.m_resp    = 1'b0;
        grant_q.delete();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h300;
        tick();
        chk1("t5_i_grant", bus.m_read, 1'b1);
        chk_v("t5_i_addr", LINE_W'(bus.m_address), LINE_W'(32'h300));
        complete(2, 1'b0, si, sd);
        chk_grants("t5_grants", 1, 8'b0);

        // d_read and d_write together: a write for the whole transfer.
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        bus.d_address = 32'h4000;
        bus.d_wdata   = rand_line();
        for (int t = 0; t < 3; t++) begin
            tick();
            chk1("t6_m_write", bus.m_write, 1'b1);
            chk1("t6_m_read", bus.m_read, 1'b0);
        end
        complete(0, 1'b0, si, sd);

        // Randomized traffic.
        fork
            i_agent(3000);
            d_agent(3000);
            l2_agent(3000);
        join
        bus.i_read  = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.m_resp  = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
